morse_char_decoder: RTL and testbench

Parametrised Morse symbol-to-character decoder. It accumulates DIT/DAH symbols into a bounded buffer and decodes the sequence on GAP or SPACE. The result is a registered character strobe with error flagging, word-space emission and a ready handshake. It sits between the keying/timing classifier, which produces the 3-bit symbol codes, and the character sink (display or UART formatter). It replaces the single-letter tree FSM with one table-driven block that has an explicit output strobe.

---
 rtl/morse_char_decoder_if.sv | 23 ++
 rtl/morse_char_decoder.sv | 164 ++++++++++++++++
 tb/tb_morse_char_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/morse_char_decoder_if.sv
// Symbol-in / character-out handshake bundle for morse_char_decoder.
// master = upstream symbol source and character sink, slave = decoder.
interface morse_char_decoder_if #(
    parameter int CODE_W = 6
);
    logic              sym_valid;
    logic [2:0]        sym;
    logic              sym_ready;
    logic              char_valid;
    logic [CODE_W-1:0] char_code;
    logic              char_err;
    logic [2:0]        sym_count;

    modport master (
        output sym_valid, sym,
        input  sym_ready, char_valid, char_code, char_err, sym_count
    );

    modport slave (
        input  sym_valid, sym,
        output sym_ready, char_valid, char_code, char_err, sym_count
    );
endinterface

// File: rtl/morse_char_decoder.sv
// Table-driven Morse symbol-to-character decoder with registered strobe and word-space collapse.
// Define MORSE_DIGITS_EN to decode 5-symbol digit patterns (requires MAX_LEN >= 5).
module morse_char_decoder #(
    parameter int MAX_LEN = 5,
    parameter int CODE_W  = 6
) (
    input logic            clk,
    input logic            reset_n,
    morse_char_decoder_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCUM    = 2'd1;
    localparam logic [1:0] FLUSH_SP = 2'd2;

    localparam logic [2:0] SYM_DIT   = 3'd1;
    localparam logic [2:0] SYM_DAH   = 3'd2;
    localparam logic [2:0] SYM_GAP   = 3'd3;
    localparam logic [2:0] SYM_SPACE = 3'd4;

    localparam logic [5:0] CODE_SPACE = 6'd37;
    localparam logic [5:0] CODE_ERR   = 6'd63;

    localparam logic [2:0] LEN_MAX = 3'(MAX_LEN);
    localparam logic [2:0] LEN_OVF = 3'(MAX_LEN + 1);

    if (MAX_LEN < 4 || MAX_LEN > 6) begin : g_bad_len
        $error("morse_char_decoder: MAX_LEN must be 4..6");
    end
    if (CODE_W < 6 || CODE_W > 8) begin : g_bad_code_w
        $error("morse_char_decoder: CODE_W must be 6..8");
    end
`ifdef MORSE_DIGITS_EN
    if (MAX_LEN < 5) begin : g_bad_digits
        $error("morse_char_decoder: MORSE_DIGITS_EN needs MAX_LEN >= 5");
    end
`endif

    logic [1:0]         state;
    logic [MAX_LEN-1:0] seq;
    logic [2:0]         len;
    logic               last_space;
    logic               xfer;
    logic               overflow;
    logic [7:0]         seq_ext;
    logic [5:0]         decoded;

    // Pattern is right-aligned: first symbol sits at bit len-1, DIT=0, DAH=1.
    function automatic logic [5:0] lookup(input logic [2:0] l, input logic [4:0] p);
        case ({l, p})
            {3'd1, 5'b00000}: lookup = 6'd5;   // E
            {3'd1, 5'b00001}: lookup = 6'd20;  // T
            {3'd2, 5'b00000}: lookup = 6'd9;   // I
            {3'd2, 5'b00001}: lookup = 6'd1;   // A
            {3'd2, 5'b00010}: lookup = 6'd14;  // N
            {3'd2, 5'b00011}: lookup = 6'd13;  // M
            {3'd3, 5'b00000}: lookup = 6'd19;  // S
            {3'd3, 5'b00001}: lookup = 6'd21;  // U
            {3'd3, 5'b00010}: lookup = 6'd18;  // R
            {3'd3, 5'b00011}: lookup = 6'd23;  // W
            {3'd3, 5'b00100}: lookup = 6'd4;   // D
            {3'd3, 5'b00101}: lookup = 6'd11;  // K
            {3'd3, 5'b00110}: lookup = 6'd7;   // G
            {3'd3, 5'b00111}: lookup = 6'd15;  // O
            {3'd4, 5'b00000}: lookup = 6'd8;   // H
            {3'd4, 5'b00001}: lookup = 6'd22;  // V
            {3'd4, 5'b00010}: lookup = 6'd6;   // F
            {3'd4, 5'b00100}: lookup = 6'd12;  // L
            {3'd4, 5'b00110}: lookup = 6'd16;  // P
            {3'd4, 5'b00111}: lookup = 6'd10;  // J
            {3'd4, 5'b01000}: lookup = 6'd2;   // B
            {3'd4, 5'b01001}: lookup = 6'd24;  // X
            {3'd4, 5'b01010}: lookup = 6'd3;   // C
            {3'd4, 5'b01011}: lookup = 6'd25;  // Y
            {3'd4, 5'b01100}: lookup = 6'd26;  // Z
            {3'd4, 5'b01101}: lookup = 6'd17;  // Q
`ifdef MORSE_DIGITS_EN
            {3'd5, 5'b11111}: lookup = 6'd27;  // 0
            {3'd5, 5'b01111}: lookup = 6'd28;  // 1
            {3'd5, 5'b00111}: lookup = 6'd29;  // 2
            {3'd5, 5'b00011}: lookup = 6'd30;  // 3
            {3'd5, 5'b00001}: lookup = 6'd31;  // 4
            {3'd5, 5'b00000}: lookup = 6'd32;  // 5
            {3'd5, 5'b10000}: lookup = 6'd33;  // 6
            {3'd5, 5'b11000}: lookup = 6'd34;  // 7
            {3'd5, 5'b11100}: lookup = 6'd35;  // 8
            {3'd5, 5'b11110}: lookup = 6'd36;  // 9
`endif
            default:          lookup = CODE_ERR;
        endcase
    endfunction

    assign bus.sym_ready = (state != FLUSH_SP);
    assign bus.sym_count = overflow ? LEN_MAX : len;
    assign xfer          = bus.sym_valid && bus.sym_ready;
    assign overflow      = (len > LEN_MAX);
    assign seq_ext       = 8'(seq);
    assign decoded       = overflow ? CODE_ERR : lookup(len, seq_ext[4:0]);

    // NOTE: every state register below uses <= so all reads see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            seq            <= '0;
            len            <= '0;
            last_space     <= 1'b1;
            bus.char_valid <= 1'b0;
            bus.char_code  <= '0;
            bus.char_err   <= 1'b0;
        end else begin
            bus.char_valid <= 1'b0;
            bus.char_code  <= '0;
            bus.char_err   <= 1'b0;

            if (state == FLUSH_SP) begin
                bus.char_valid <= 1'b1;
                bus.char_code  <= CODE_W'(CODE_SPACE);
                last_space     <= 1'b1;
                state          <= IDLE;
            end else if (xfer) begin
                case (bus.sym)
                    SYM_DIT, SYM_DAH: begin
                        // Symbols past MAX_LEN are dropped; len parks at LEN_OVF.
                        if (len < LEN_MAX) begin
                            seq <= {seq[MAX_LEN-2:0], bus.sym == SYM_DAH};
                            len <= len + 3'd1;
                        end else begin
                            len <= LEN_OVF;
                        end
                        state <= ACCUM;
                    end
                    SYM_GAP: begin
                        if (len != '0) begin
                            bus.char_valid <= 1'b1;
                            bus.char_code  <= CODE_W'(decoded);
                            bus.char_err   <= (decoded == CODE_ERR);
                            last_space     <= 1'b0;
                            seq            <= '0;
                            len            <= '0;
                            state          <= IDLE;
                        end
                    end
                    SYM_SPACE: begin
                        if (len == '0) begin
                            if (!last_space) begin
                                bus.char_valid <= 1'b1;
                                bus.char_code  <= CODE_W'(CODE_SPACE);
                            end
                            last_space <= 1'b1;
                        end else begin
                            bus.char_valid <= 1'b1;
                            bus.char_code  <= CODE_W'(decoded);
                            bus.char_err   <= (decoded == CODE_ERR);
                            last_space     <= 1'b0;
                            seq            <= '0;
                            len            <= '0;
                            state          <= FLUSH_SP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_morse_char_decoder.sv
// Directed self-checking bench for morse_char_decoder (MAX_LEN=5, CODE_W=6).
// Digit expectations follow MORSE_DIGITS_EN when it is defined for the build.
module tb_morse_char_decoder;
    localparam logic [2:0] WAIT  = 3'd0;
    localparam logic [2:0] DIT   = 3'd1;
    localparam logic [2:0] DAH   = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] SPACE = 3'd4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;
    int   exp_strobes = 0;

    morse_char_decoder_if #(.CODE_W(6)) bus ();

    morse_char_decoder #(.MAX_LEN(5), .CODE_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.char_valid) strobes++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] s);
        int guard = 0;
        while (!bus.sym_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.sym_ready) check("ready_timeout", 32'(bus.sym_ready), 1);
        bus.sym_valid = 1'b1;
        bus.sym       = s;
        @(negedge clk);
        bus.sym_valid = 1'b0;
        bus.sym       = WAIT;
    endtask

    task automatic expect_char(input string tag, input int code, input bit err);
        check({tag, "_valid"}, 32'(bus.char_valid), 1);
        check({tag, "_code"},  32'(bus.char_code), code);
        check({tag, "_err"},   32'(bus.char_err), 32'(err));
        exp_strobes++;
    endtask

    task automatic expect_none(input string tag);
        check({tag, "_none"}, 32'(bus.char_valid), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sym_valid = 1'b0;
        bus.sym       = WAIT;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.char_valid), 0);
        check("rst_code",  32'(bus.char_code), 0);
        check("rst_err",   32'(bus.char_err), 0);
        check("rst_ready", 32'(bus.sym_ready), 1);
        check("rst_count", 32'(bus.sym_count), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Leading space after reset is suppressed
        send(SPACE); expect_none("lead_sp");
        @(negedge clk); expect_none("lead_sp2");

        // A then X, with one-cycle strobe
        send(DIT); send(DAH); send(GAP); expect_char("A", 1, 0);
        @(negedge clk); expect_none("A_one_cycle");
        send(DAH); send(DIT); send(DIT); send(DAH); send(GAP); expect_char("X", 24, 0);

        // Z with sym_count stepping, then a back-to-back GAP emits nothing
        send(DAH); check("cnt1", 32'(bus.sym_count), 1);
        send(DAH); check("cnt2", 32'(bus.sym_count), 2);
        send(DIT); check("cnt3", 32'(bus.sym_count), 3);
        send(DIT); check("cnt4", 32'(bus.sym_count), 4);
        send(GAP); expect_char("Z", 26, 0);
        check("cnt0", 32'(bus.sym_count), 0);
        send(GAP); expect_none("gap_gap");

        // Overflow: six DITs then GAP is an error, recovery to E
        for (int i = 0; i < 5; i++) send(DIT);
        check("cnt5", 32'(bus.sym_count), 5);
        send(DIT); check("cnt_clamp", 32'(bus.sym_count), 5);
        send(GAP); expect_char("ovf", 63, 1);
        send(DIT); send(GAP); expect_char("E", 5, 0);

        // SPACE flushing a character, then collapse
        send(DIT); send(SPACE); expect_char("flush_E", 5, 0);
        check("flush_ready0", 32'(bus.sym_ready), 0);
        @(negedge clk); expect_char("flush_sp", 37, 0);
        check("flush_ready1", 32'(bus.sym_ready), 1);
        send(SPACE); expect_none("dup_sp");
        send(DAH); send(GAP); expect_char("T", 20, 0);
        send(SPACE); expect_char("word_sp", 37, 0);
        send(SPACE); expect_none("word_sp_dup");

        // Digits 0 and 1
        for (int i = 0; i < 5; i++) send(DAH);
        send(GAP);
`ifdef MORSE_DIGITS_EN
        expect_char("dig0", 27, 0);
`else
        expect_char("dig0", 63, 1);
`endif
        send(DIT); for (int i = 0; i < 4; i++) send(DAH);
        send(GAP);
`ifdef MORSE_DIGITS_EN
        expect_char("dig1", 28, 0);
`else
        expect_char("dig1", 63, 1);
`endif

        // Unmapped 4-symbol pattern is an error, which re-arms the space
        send(DIT); send(DIT); send(DAH); send(DAH); send(GAP); expect_char("unmapped", 63, 1);
        send(SPACE); expect_char("sp_after_err", 37, 0);

        // WAIT and reserved codes are ignored mid-sequence
        send(DIT); send(WAIT); check("wait_cnt", 32'(bus.sym_count), 1);
        send(3'd7); send(3'd5); send(DAH); send(GAP); expect_char("A_rsvd", 1, 0);

        // Reset mid-sequence discards the buffer
        send(DIT); send(DIT);
        reset_n = 1'b0;
        @(negedge clk); expect_none("rst_mid");
        check("rst_mid_cnt", 32'(bus.sym_count), 0);
        reset_n = 1'b1;
        @(negedge clk);
        send(DAH); send(GAP); expect_char("T_after_rst", 20, 0);

        // Reset during FLUSH_SP discards the pending space
        send(DIT); send(SPACE); expect_char("E_pre_rst", 5, 0);
        reset_n = 1'b0;
        @(negedge clk); expect_none("rst_flush");
        reset_n = 1'b1;
        @(negedge clk); expect_none("rst_flush_after");
        check("rst_flush_ready", 32'(bus.sym_ready), 1);
        send(SPACE); expect_none("sp_after_rst");

        repeat (2) @(negedge clk);
        check("strobe_total", 32'(strobes), 32'(exp_strobes));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
